// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side sequencer for a UART SIPO shift register.
//   Synchronises RX_in, qualifies the start bit at mid-bit, pulses `shift` at
//   every data (and parity) bit centre, then checks stop/parity and strobes
//   the byte read back from the SIPO with a one-cycle rx_valid.
// Optional build macro: UART_RX_PARITY_EN adds a parity bit after the data
//   bits (PARITY_ODD selects odd/even); without it parity_err is tied low.
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   RX_in           raw asynchronous serial line (idle high)
//   rx_sync         synchronised line, also feeds the SIPO serial input
//   shift           SIPO shift pulse at each data/parity bit centre
//   sipo_out        SIPO parallel output, read when the frame completes
//   rx_data         received byte, bit 0 = first bit on the line
//   rx_valid        one-cycle strobe qualifying rx_data and the error flags
//   parity_err      parity mismatch on the last frame (held)
//   frame_err       stop bit sampled low on the last frame (held)
//   busy            high whenever the sequencer is not idle
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RX_in,
  output logic                 rx_sync,
  output logic                 shift,
  input  logic [DATA_BITS+1:0] sipo_out,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  // The parity bit is the last one shifted in, so the payload sits one
  // position higher in the SIPO.
  localparam int P = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;
`else
  localparam int P = 0;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
  } state_t;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               par_q, par_d;
  logic               sync_meta, sync_q;
  logic               done;
  logic [DATA_BITS-1:0] data_rev;
  logic               unused_sipo;

  assign rx_sync = sync_q;
  assign busy    = (state_q != S_IDLE);

`ifdef UART_RX_PARITY_EN
  assign unused_sipo = ^{sipo_out[DATA_BITS+1], sipo_out[0]};
`else
  assign unused_sipo = ^{sipo_out[DATA_BITS+1:DATA_BITS], PARITY_ODD};
`endif

  // The SIPO shifts towards its MSB, so the first bit received ends up
  // highest; undo that so rx_data[0] is the first bit on the line.
  always_comb begin
    data_rev = '0;
    for (int i = 0; i < DATA_BITS; i++) begin
      data_rev[i] = sipo_out[DATA_BITS - 1 - i + P];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    par_d   = par_q;
    shift   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rx_sync) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          // Line back high at mid start bit: a glitch, not a frame.
          if (!rx_sync) begin
            state_d = S_DATA;
            idx_d   = '0;
            par_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          shift = 1'b1;
          par_d = par_q ^ rx_sync;
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          shift   = 1'b1;
          // Folding the parity bit into the running XOR leaves par_q equal
          // to (data XOR parity), i.e. 0 for a frame with even parity.
          par_d   = par_q ^ rx_sync;
          cnt_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          done    = 1'b1;
          cnt_d   = '0;
          state_d = rx_sync ? S_IDLE : S_BREAK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BREAK: begin
        // Hold off until the line recovers so a long low is one frame only.
        if (rx_sync) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_meta  <= 1'b1;
      sync_q     <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      par_q      <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync_meta <= RX_in;
      sync_q    <= sync_meta;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      par_q     <= par_d;
      rx_valid  <= done;
      if (done) begin
        rx_data   <= data_rev;
        frame_err <= ~rx_sync;
`ifdef UART_RX_PARITY_EN
        parity_err <= par_q ^ PARITY_ODD;
`else
        parity_err <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: self-checking bench for uart_rx_ctrl.
//   Drives serial frames on RX_in, models the external SIPO register, and
//   compares strobes, data, flags and timing against line-level expectations.
module tb_uart_rx_ctrl;

  localparam int CPB  = 16;
  localparam int DB   = 8;
  localparam bit PODD = 1'b0;

`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB = DB + P;                      // shifted bits per frame
  // rx_valid: 2 sync flops + 1 idle detect + half a bit + (NB+1) bit periods
  // to the stop centre + 1 registered strobe, counted from the drive edge.
  localparam int LAT         = 3 + CPB / 2 + (NB + 1) * CPB;
  localparam int FIRST_SHIFT = 2 + CPB / 2 + CPB;  // centre of data bit 0
  localparam int FRAME_LEN   = (NB + 2) * CPB;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          RX_in = 1'b1;
  logic          rx_sync, shift, rx_valid, parity_err, frame_err, busy;
  logic [DB+1:0] sipo_out = '0;
  logic [DB-1:0] rx_data;

  uart_rx_ctrl #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB),
    .PARITY_ODD  (PODD)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_in     (RX_in),
    .rx_sync   (rx_sync),
    .shift     (shift),
    .sipo_out  (sipo_out),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  // External SIPO: shifts rx_sync in at the LSB on each shift pulse.
  always @(posedge CLK) begin
    if (RST) sipo_out <= '0;
    else if (shift) sipo_out <= {sipo_out[DB:0], rx_sync};
  end

  typedef struct {
    logic [DB-1:0] data;
    logic          perr;
    logic          ferr;
    int            at;
  } rec_t;

  int   cyc = 0;
  rec_t vq[$];
  int   sq[$];
  int   overlap = 0;
  int   busy_cnt = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    rec_t r;
    if (rx_valid) begin
      r.data = rx_data; r.perr = parity_err; r.ferr = frame_err; r.at = cyc;
      vq.push_back(r);
    end
    if (shift) sq.push_back(cyc);
    if (shift && rx_valid) overlap++;
    if (busy) busy_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic drive_bit(input logic v);
    RX_in = v;
    idle(CPB);
  endtask

  // fbits holds data bits then the parity bit; only NB of them are sent.
  task automatic send_frame(input logic [DB:0] fbits, input logic stop, output int start);
    start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < NB; i++) drive_bit(fbits[i]);
    drive_bit(stop);
  endtask

  function automatic logic exp_perr(input logic [DB-1:0] d, input logic pb);
    return (P == 1) ? (^d ^ pb ^ PODD) : 1'b0;
  endfunction

  task automatic test_reset();
    RST = 1'b1; RX_in = 1'b0;
    idle(3);
    total_cnt++; if (rx_sync !== 1'b1) $display("FAIL reset_rx_sync got=%b exp=1", rx_sync); else pass_cnt++;
    total_cnt++; if ({shift, rx_valid, parity_err, frame_err, busy} !== 5'b0)
      $display("FAIL reset_flags got=%b exp=00000", {shift, rx_valid, parity_err, frame_err, busy}); else pass_cnt++;
    total_cnt++; if (rx_data !== '0) $display("FAIL reset_rx_data got=%h exp=00", rx_data); else pass_cnt++;
    RX_in = 1'b1;
    idle(3);
    RST = 1'b0;
    idle(4);
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_idle_busy got=%b exp=0", busy); else pass_cnt++;
  endtask

  task automatic test_clean();
    logic [DB-1:0] d;
    logic          pb;
    int            s;
    for (int n = 0; n < 6; n++) begin
      d  = (n == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
      pb = ^d ^ PODD;
      vq.delete(); sq.delete();
      send_frame({pb, d}, 1'b1, s);
      idle(4);
      total_cnt++; if (vq.size() != 1) $display("FAIL clean_valid_count got=%0d exp=1", vq.size()); else pass_cnt++;
      if (vq.size() > 0) begin
        total_cnt++; if (vq[0].data !== d) $display("FAIL clean_data got=%h exp=%h", vq[0].data, d); else pass_cnt++;
        total_cnt++; if ({vq[0].perr, vq[0].ferr} !== 2'b00)
          $display("FAIL clean_flags got=%b exp=00", {vq[0].perr, vq[0].ferr}); else pass_cnt++;
        total_cnt++; if (vq[0].at != s + LAT) $display("FAIL clean_valid_time got=%0d exp=%0d", vq[0].at - s, LAT); else pass_cnt++;
      end
      total_cnt++; if (sq.size() != NB) $display("FAIL clean_shift_count got=%0d exp=%0d", sq.size(), NB); else pass_cnt++;
      if (sq.size() > 0) begin
        total_cnt++; if (sq[0] != s + FIRST_SHIFT)
          $display("FAIL clean_first_shift got=%0d exp=%0d", sq[0] - s, FIRST_SHIFT); else pass_cnt++;
      end
      for (int k = 1; k < sq.size(); k++) begin
        total_cnt++; if (sq[k] - sq[k-1] != CPB)
          $display("FAIL clean_shift_gap got=%0d exp=%0d", sq[k] - sq[k-1], CPB); else pass_cnt++;
      end
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity_err();
    logic [DB-1:0] d;
    int            s;
    vq.delete();
    d = 8'h3C;
    send_frame({1'b1, d}, 1'b1, s);
    idle(20);
    total_cnt++; if (vq.size() != 1) $display("FAIL par_valid_count got=%0d exp=1", vq.size()); else pass_cnt++;
    if (vq.size() > 0) begin
      total_cnt++; if (vq[0].data !== d) $display("FAIL par_data got=%h exp=%h", vq[0].data, d); else pass_cnt++;
      total_cnt++; if (vq[0].perr !== exp_perr(d, 1'b1))
        $display("FAIL par_err got=%b exp=%b", vq[0].perr, exp_perr(d, 1'b1)); else pass_cnt++;
    end
    total_cnt++; if (parity_err !== 1'b1) $display("FAIL par_err_hold got=%b exp=1", parity_err); else pass_cnt++;
    vq.delete();
    d = 8'($urandom_range(0, 255));
    send_frame({^d ^ PODD, d}, 1'b1, s);
    idle(4);
    total_cnt++; if (vq.size() != 1 || vq[0].perr !== 1'b0 || vq[0].data !== d)
      $display("FAIL par_clear got_count=%0d got_perr=%b exp_perr=0", vq.size(), parity_err); else pass_cnt++;
  endtask
`endif

  task automatic test_glitch();
    vq.delete(); sq.delete();
    busy_cnt = 0;
    RX_in = 1'b0;
    idle(5);
    RX_in = 1'b1;
    idle(30);
    total_cnt++; if (busy_cnt < 1 || busy_cnt > 10) $display("FAIL glitch_busy_cycles got=%0d exp=1..10", busy_cnt); else pass_cnt++;
    total_cnt++; if (sq.size() != 0) $display("FAIL glitch_shift got=%0d exp=0", sq.size()); else pass_cnt++;
    total_cnt++; if (vq.size() != 0) $display("FAIL glitch_valid got=%0d exp=0", vq.size()); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL glitch_idle got=%b exp=0", busy); else pass_cnt++;
  endtask

  task automatic test_break();
    int s;
    vq.delete();
    send_frame({1'b0, 8'h00}, 1'b0, s);
    RX_in = 1'b0;
    idle(200);
    total_cnt++; if (vq.size() != 1) $display("FAIL break_valid_count got=%0d exp=1", vq.size()); else pass_cnt++;
    if (vq.size() > 0) begin
      total_cnt++; if (vq[0].ferr !== 1'b1 || vq[0].data !== 8'h00)
        $display("FAIL break_frame got_ferr=%b got_data=%h exp_ferr=1 exp_data=00", vq[0].ferr, vq[0].data); else pass_cnt++;
    end
    total_cnt++; if (busy !== 1'b1) $display("FAIL break_busy got=%b exp=1", busy); else pass_cnt++;
    total_cnt++; if (frame_err !== 1'b1) $display("FAIL break_ferr_hold got=%b exp=1", frame_err); else pass_cnt++;
    RX_in = 1'b1;
    idle(6);
    total_cnt++; if (busy !== 1'b0) $display("FAIL break_release got=%b exp=0", busy); else pass_cnt++;
    vq.delete();
    send_frame({1'b0, 8'h55}, 1'b1, s);  // 0x55 has even weight: parity 0
    idle(4);
    total_cnt++; if (vq.size() != 1 || vq[0].data !== 8'h55 || vq[0].ferr !== 1'b0)
      $display("FAIL break_next_frame got_count=%0d got_data=%h got_ferr=%b exp=1/55/0",
               vq.size(), rx_data, frame_err); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int s;
    vq.delete();
    RX_in = 1'b0;
    idle(CPB);
    RX_in = 1'b1;
    idle(4 * CPB + CPB / 2);  // bits 0..3 of 0xFF, then halfway into bit 4
    total_cnt++; if (busy !== 1'b1) $display("FAIL rstmid_busy_before got=%b exp=1", busy); else pass_cnt++;
    RST = 1'b1;
    idle(1);
    total_cnt++; if ({rx_sync, shift, rx_valid, parity_err, frame_err, busy} !== 6'b100000)
      $display("FAIL rstmid_outputs got=%b exp=100000", {rx_sync, shift, rx_valid, parity_err, frame_err, busy}); else pass_cnt++;
    total_cnt++; if (rx_data !== '0) $display("FAIL rstmid_rx_data got=%h exp=00", rx_data); else pass_cnt++;
    RST = 1'b0;
    idle(3 * CPB);
    total_cnt++; if (vq.size() != 0) $display("FAIL rstmid_no_valid got=%0d exp=0", vq.size()); else pass_cnt++;
    send_frame({1'b0, 8'h81}, 1'b1, s);
    idle(4);
    total_cnt++; if (vq.size() != 1 || vq[0].data !== 8'h81)
      $display("FAIL rstmid_next_frame got_count=%0d got_data=%h exp=1/81", vq.size(), rx_data); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [DB-1:0] d0, d1;
    int            s0, s1;
    for (int n = 0; n < 3; n++) begin
      d0 = (n == 0) ? 8'h96 : 8'($urandom_range(0, 255));
      d1 = (n == 0) ? 8'h69 : 8'($urandom_range(0, 255));
      vq.delete(); sq.delete(); overlap = 0;
      send_frame({^d0 ^ PODD, d0}, 1'b1, s0);
      send_frame({^d1 ^ PODD, d1}, 1'b1, s1);
      idle(4);
      total_cnt++; if (s1 - s0 != FRAME_LEN) $display("FAIL b2b_gap got=%0d exp=%0d", s1 - s0, FRAME_LEN); else pass_cnt++;
      total_cnt++; if (vq.size() != 2) $display("FAIL b2b_valid_count got=%0d exp=2", vq.size()); else pass_cnt++;
      if (vq.size() == 2) begin
        total_cnt++; if (vq[0].data !== d0 || vq[1].data !== d1)
          $display("FAIL b2b_data got=%h,%h exp=%h,%h", vq[0].data, vq[1].data, d0, d1); else pass_cnt++;
        total_cnt++; if ({vq[0].perr, vq[1].perr} !== {exp_perr(d0, ^d0 ^ PODD), exp_perr(d1, ^d1 ^ PODD)})
          $display("FAIL b2b_perr got=%b%b exp=00", vq[0].perr, vq[1].perr); else pass_cnt++;
        total_cnt++; if (vq[0].at != s0 + LAT || vq[1].at != s1 + LAT)
          $display("FAIL b2b_time got=%0d,%0d exp=%0d,%0d", vq[0].at - s0, vq[1].at - s1, LAT, LAT); else pass_cnt++;
      end
      total_cnt++; if (sq.size() != 2 * NB) $display("FAIL b2b_shift_count got=%0d exp=%0d", sq.size(), 2 * NB); else pass_cnt++;
      total_cnt++; if (overlap != 0) $display("FAIL b2b_shift_valid_overlap got=%0d exp=0", overlap); else pass_cnt++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean();
`ifdef UART_RX_PARITY_EN
    test_parity_err();
`endif
    test_glitch();
    test_break();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
